// File: rtl/board_pixel_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : board_pixel_renderer
//  Purpose  : Game-layer pixel generator. Maps the VGA scan position onto an
//             NxN board of square cells, looks up each cell's {owner,type}
//             in a register store written by game logic, and produces the
//             game-layer colour two pixel clocks later. Also draws a
//             blinking cursor outline on one selected cell.
//  Ports    : clk_vga, reset            pixel clock, sync active-high reset
//             hdata, vdata              scan column / row
//             wr_valid/wr_ready         cell write handshake
//             wr_row, wr_col            target cell
//             wr_owner, wr_type         cell contents
//             clear_i                   restart the clear sweep
//             cursor_row, cursor_col    cursor cell
//             gen_red/green/blue        game-layer colour
//             use_gen                   pixel lies on the board
//  Options  : GRID_LINES_EN - when defined, the first row and column of
//             every cell are drawn black (the cursor still overrides).
//  Revision : 1.0  initial release
// ============================================================================
module board_pixel_renderer #(
  parameter int WIDTH        = 12,
  parameter int BOARD_X0     = 50,
  parameter int BOARD_Y0     = 50,
  parameter int CELL         = 50,
  parameter int N            = 10,
  parameter int BLINK_FRAMES = 32
) (
  input  logic             clk_vga,
  input  logic             reset,
  input  logic [WIDTH-1:0] hdata,
  input  logic [WIDTH-1:0] vdata,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [3:0]       wr_row,
  input  logic [3:0]       wr_col,
  input  logic [1:0]       wr_owner,
  input  logic [1:0]       wr_type,
  input  logic             clear_i,
  input  logic [3:0]       cursor_row,
  input  logic [3:0]       cursor_col,
  output logic [7:0]       gen_red,
  output logic [7:0]       gen_green,
  output logic [7:0]       gen_blue,
  output logic             use_gen
);

  localparam int CELLS = N * N;
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  // Lower corner of the centred 20x20 "general" marker.
  localparam int GEN_LO = (CELL - 20) / 2;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Cell store and clear/run control
  // --------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [IDX_W-1:0]   clear_idx_q, clear_idx_d;
  logic [3:0]         cells_q [CELLS];
  logic [3:0]         cells_d [CELLS];
  logic [IDX_W-1:0]   wr_idx;
  logic               wr_in_range;

  assign wr_idx      = IDX_W'(int'(wr_row) * N + int'(wr_col));
  assign wr_in_range = ({1'b0, wr_row} < 5'(N)) && ({1'b0, wr_col} < 5'(N));
  assign wr_ready    = (state_q == ST_RUN);

  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    cells_d     = cells_q;
    case (state_q)
      ST_CLEAR: begin
        cells_d[clear_idx_q] = 4'h0;
        if (clear_i) begin
          clear_idx_d = '0;
        end else if (clear_idx_q == IDX_W'(CELLS - 1)) begin
          state_d     = ST_RUN;
          clear_idx_d = '0;
        end else begin
          clear_idx_d = clear_idx_q + 1'b1;
        end
      end
      ST_RUN: begin
        // A clear request wins over a write presented in the same cycle.
        if (clear_i) begin
          state_d     = ST_CLEAR;
          clear_idx_d = '0;
        end else if (wr_valid && wr_in_range) begin
          cells_d[wr_idx] = {wr_owner, wr_type};
        end
      end
      default: begin
        state_d     = ST_CLEAR;
        clear_idx_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame counter / cursor blink
  // --------------------------------------------------------------------------
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            blink_q, blink_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (hdata == '0 && vdata == '0) begin
      if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: board hit test and cell / in-cell coordinates
  // --------------------------------------------------------------------------
  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_row_q, s1_row_d, s1_col_q, s1_col_d;
  logic [WIDTH-1:0] s1_px_q, s1_px_d, s1_py_q, s1_py_d;
  logic [WIDTH-1:0] dx, dy;

  assign dx = hdata - WIDTH'(BOARD_X0);
  assign dy = vdata - WIDTH'(BOARD_Y0);

  always_comb begin
    s1_valid_d = (hdata >= WIDTH'(BOARD_X0)) && (hdata < WIDTH'(BOARD_X0 + N * CELL)) &&
                 (vdata >= WIDTH'(BOARD_Y0)) && (vdata < WIDTH'(BOARD_Y0 + N * CELL));
    s1_col_d   = 4'(dx / WIDTH'(CELL));
    s1_row_d   = 4'(dy / WIDTH'(CELL));
    s1_px_d    = dx % WIDTH'(CELL);
    s1_py_d    = dy % WIDTH'(CELL);
  end

  // --------------------------------------------------------------------------
  // Stage 2: cell lookup and colour composition
  // --------------------------------------------------------------------------
  logic [23:0]      gen_q, gen_d;
  logic             use_q, use_d;
  logic [IDX_W-1:0] rd_idx;
  logic [3:0]       rd_cell;
  int               px_i, py_i;
  logic             edge4, edge3, centre, cursor_hit;

  assign rd_idx = IDX_W'(int'(s1_row_q) * N + int'(s1_col_q));
  // Stage 1 only holds in-range row/col when the pixel is on the board.
  assign rd_cell = s1_valid_q ? cells_q[rd_idx] : 4'h0;
  assign px_i    = int'(s1_px_q);
  assign py_i    = int'(s1_py_q);

  assign edge4  = (px_i < 4) || (px_i >= CELL - 4) || (py_i < 4) || (py_i >= CELL - 4);
  assign edge3  = (px_i < 3) || (px_i >= CELL - 3) || (py_i < 3) || (py_i >= CELL - 3);
  assign centre = (px_i >= GEN_LO) && (px_i < GEN_LO + 20) &&
                  (py_i >= GEN_LO) && (py_i < GEN_LO + 20);
  assign cursor_hit = blink_q && edge3 &&
                      (s1_row_q == cursor_row) && (s1_col_q == cursor_col);

  always_comb begin
    logic [23:0] colour;
    case (rd_cell[3:2])
      2'd1:    colour = 24'hE04040;
      2'd2:    colour = 24'h4040E0;
      2'd3:    colour = 24'h40C040;
      default: colour = 24'h808080;
    endcase
    case (rd_cell[1:0])
      2'd1:    if (edge4)  colour = 24'h000000;
      2'd2:    if (centre) colour = 24'hFFFFFF;
      2'd3:    colour = 24'h505050;
      default: ;
    endcase
`ifdef GRID_LINES_EN
    if (px_i == 0 || py_i == 0) colour = 24'h000000;
`endif
    if (cursor_hit) colour = 24'hFFFF00;
    gen_d = s1_valid_q ? colour : 24'h000000;
    use_d = s1_valid_q;
  end

  assign gen_red   = gen_q[23:16];
  assign gen_green = gen_q[15:8];
  assign gen_blue  = gen_q[7:0];
  assign use_gen   = use_q;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clear_idx_q <= '0;
      cells_q     <= '{default: 4'h0};
      frame_cnt_q <= '0;
      blink_q     <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_row_q    <= '0;
      s1_col_q    <= '0;
      s1_px_q     <= '0;
      s1_py_q     <= '0;
      gen_q       <= '0;
      use_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
      cells_q     <= cells_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      s1_valid_q  <= s1_valid_d;
      s1_row_q    <= s1_row_d;
      s1_col_q    <= s1_col_d;
      s1_px_q     <= s1_px_d;
      s1_py_q     <= s1_py_d;
      gen_q       <= gen_d;
      use_q       <= use_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_board_pixel_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_board_pixel_renderer
//  Purpose  : Directed self-checking bench for board_pixel_renderer with the
//             default parameters (10x10 board of 50-pixel cells at 50,50).
//  Revision : 1.0  initial release
// ============================================================================
module tb_board_pixel_renderer;

  localparam logic [24:0] OFF     = 25'h0;
  localparam logic [24:0] NEUTRAL = {1'b1, 24'h808080};
  localparam logic [24:0] RED     = {1'b1, 24'hE04040};
  localparam logic [24:0] BLUE    = {1'b1, 24'h4040E0};
  localparam logic [24:0] GREEN   = {1'b1, 24'h40C040};
  localparam logic [24:0] MOUNT   = {1'b1, 24'h505050};
  localparam logic [24:0] BLACK   = {1'b1, 24'h000000};
  localparam logic [24:0] WHITE   = {1'b1, 24'hFFFFFF};
  localparam logic [24:0] CURSOR  = {1'b1, 24'hFFFF00};
`ifdef GRID_LINES_EN
  localparam logic [24:0] GRID_PX = BLACK;
`else
  localparam logic [24:0] GRID_PX = NEUTRAL;
`endif

  logic        clk_vga = 1'b0;
  logic        reset;
  logic [11:0] hdata, vdata;
  logic        wr_valid, wr_ready;
  logic [3:0]  wr_row, wr_col;
  logic [1:0]  wr_owner, wr_type;
  logic        clear_i;
  logic [3:0]  cursor_row, cursor_col;
  logic [7:0]  gen_red, gen_green, gen_blue;
  logic        use_gen;

  int total = 0;
  int bad   = 0;

  board_pixel_renderer dut (
    .clk_vga    (clk_vga),
    .reset      (reset),
    .hdata      (hdata),
    .vdata      (vdata),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_owner   (wr_owner),
    .wr_type    (wr_type),
    .clear_i    (clear_i),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .gen_red    (gen_red),
    .gen_green  (gen_green),
    .gen_blue   (gen_blue),
    .use_gen    (use_gen)
  );

  always #5 clk_vga = ~clk_vga;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  // Advance one clock; leaves time 1 unit past the rising edge.
  task automatic tick();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic chk_px(input string tag, input logic [24:0] exp);
    logic [24:0] obs;
    obs = {use_gen, gen_red, gen_green, gen_blue};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic scan(input string tag, input int h, input int v, input logic [24:0] exp);
    hdata = 12'(h);
    vdata = 12'(v);
    tick();
    tick();
    chk_px(tag, exp);
  endtask

  task automatic write_cell(input int r, input int c, input int own, input int typ);
    wr_row   = 4'(r);
    wr_col   = 4'(c);
    wr_owner = 2'(own);
    wr_type  = 2'(typ);
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      hdata = 12'd0;
      vdata = 12'd0;
      tick();
    end
    hdata = 12'd600;
    vdata = 12'd600;
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    hdata      = 12'd600;
    vdata      = 12'd600;
    wr_valid   = 1'b1;
    wr_row     = 4'd12;
    wr_col     = 4'd3;
    wr_owner   = 2'd2;
    wr_type    = 2'd0;
    clear_i    = 1'b0;
    cursor_row = 4'd15;
    cursor_col = 4'd15;

    // Reset state, with a write request already held.
    repeat (3) tick();
    chk_px("reset_out", OFF);
    chk_int("reset_ready", int'(wr_ready), 0);

    // Initial clear sweep: ready low for exactly 100 cycles.
    reset = 1'b0;
    n = 0;
    while (!wr_ready && n < 300) begin
      tick();
      n++;
    end
    chk_int("clear_len", n, 100);
    wr_valid = 1'b0;
    scan("cleared_23", 225, 175, NEUTRAL);

    // Write red to (2,3); check the exact 2-cycle latency.
    write_cell(2, 3, 1, 0);
    hdata = 12'd600;
    vdata = 12'd600;
    tick();
    tick();
    hdata = 12'd225;
    vdata = 12'd175;
    tick();
    chk_px("latency_1", OFF);
    tick();
    chk_px("red_23", RED);

    // Board boundaries.
    scan("left_49", 49, 175, OFF);
    scan("right_550", 550, 175, OFF);
    scan("below_550", 225, 550, OFF);
    scan("corner_50", 50, 50, GRID_PX);
    scan("last_549", 549, 549, NEUTRAL);

    // Cell types and owners.
    write_cell(4, 4, 2, 3);
    scan("mountain", 275, 275, MOUNT);
    write_cell(5, 5, 3, 1);
    scan("city_edge", 302, 325, BLACK);
    scan("city_mid", 325, 325, GREEN);
    write_cell(6, 6, 2, 2);
    scan("general_mid", 375, 375, WHITE);
    scan("general_out", 360, 375, BLUE);
    scan("grid_100_75", 100, 75, GRID_PX);

    // Out-of-range write is ignored; the store keeps its contents.
    write_cell(10, 3, 3, 3);
    scan("oob_red_23", 225, 175, RED);

    // Write and read of the same cell in the same cycle.
    hdata = 12'd425;
    vdata = 12'd425;
    tick();
    wr_row   = 4'd7;
    wr_col   = 4'd7;
    wr_owner = 2'd1;
    wr_type  = 2'd0;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    chk_px("same_cyc_old", NEUTRAL);
    tick();
    chk_px("same_cyc_new", RED);

    // Cursor blink on cell (0,0).
    cursor_row = 4'd0;
    cursor_col = 4'd0;
    scan("cursor_blink0", 51, 51, NEUTRAL);
    frames(32);
    scan("cursor_blink1", 51, 51, CURSOR);
    scan("cursor_corner", 50, 50, CURSOR);
    scan("cursor_inner", 75, 75, NEUTRAL);
    frames(31);
    scan("cursor_31", 51, 51, CURSOR);
    frames(1);
    scan("cursor_off", 51, 51, NEUTRAL);
    cursor_row = 4'd15;
    cursor_col = 4'd15;

    // Clear with a simultaneous write: write dropped, full resweep.
    wr_row   = 4'd8;
    wr_col   = 4'd8;
    wr_owner = 2'd1;
    wr_type  = 2'd0;
    wr_valid = 1'b1;
    clear_i  = 1'b1;
    tick();
    clear_i  = 1'b0;
    wr_valid = 1'b0;
    n = 0;
    while (!wr_ready && n < 300) begin
      tick();
      n++;
    end
    chk_int("reclear_len", n, 100);
    scan("reclear_88", 475, 475, NEUTRAL);
    scan("reclear_23", 225, 175, NEUTRAL);
    scan("reclear_44", 275, 275, NEUTRAL);

    // Reset in the middle of an on-board scan.
    write_cell(2, 3, 1, 0);
    scan("pre_reset", 225, 175, RED);
    reset = 1'b1;
    tick();
    chk_px("mid_reset", OFF);
    chk_int("mid_reset_rdy", int'(wr_ready), 0);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
